// File: rtl/frog_game_ctrl.sv
// Frog crossing game controller: one frog steered by buttons, one car
// looping across a fixed lane. All game state advances once per video frame.
module frog_game_ctrl #(
    parameter int TILE_SIZE      = 32,
    parameter int H_VISIBLE_AREA = 640,
    parameter int V_VISIBLE_AREA = 480,
    parameter int CAR_SPEED      = 2,
    parameter int CAR_LANE_Y     = 224,
    parameter int HIT_FRAMES     = 60
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic       i_Frame_Start,
    input  logic       i_Btn_Up,
    input  logic       i_Btn_Down,
    input  logic       i_Btn_Left,
    input  logic       i_Btn_Right,
    output logic [9:0] o_Frog_X,
    output logic [9:0] o_Frog_Y,
    output logic [9:0] o_Car_X,
    output logic [9:0] o_Car_Y,
    output logic       o_Collision,
    output logic [3:0] o_Level,
    output logic [1:0] o_State
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_PLAY = 2'b01,
        S_HIT  = 2'b10,
        S_WIN  = 2'b11
    } state_t;

    localparam logic [9:0]  TILE10  = 10'(TILE_SIZE);
    localparam logic [9:0]  X_MAX   = 10'(H_VISIBLE_AREA - TILE_SIZE);
    localparam logic [9:0]  Y_MAX   = 10'(V_VISIBLE_AREA - TILE_SIZE);
    localparam logic [9:0]  FROG_X0 = 10'((H_VISIBLE_AREA - TILE_SIZE) / 2);
    localparam logic [9:0]  FROG_Y0 = 10'(V_VISIBLE_AREA - TILE_SIZE);
    localparam logic [9:0]  CAR_Y0  = 10'(CAR_LANE_Y);
    localparam logic [9:0]  STEP10  = 10'(CAR_SPEED);
    localparam logic [10:0] H_AREA  = 11'(H_VISIBLE_AREA);
    localparam logic [15:0] HIT_LEN = 16'(HIT_FRAMES);

    // One tile toward zero, clamped at the screen edge.
    function automatic logic [9:0] step_dec(input logic [9:0] p);
        return (p >= TILE10) ? (p - TILE10) : 10'd0;
    endfunction

    // One tile away from zero, clamped at the last full tile position.
    function automatic logic [9:0] step_inc(input logic [9:0] p, input logic [9:0] lim);
        logic [10:0] s;
        s = {1'b0, p} + {1'b0, TILE10};
        return (s > {1'b0, lim}) ? lim : s[9:0];
    endfunction

    // Level counter that sticks at its maximum.
    function automatic logic [3:0] level_inc(input logic [3:0] l);
        return (l == 4'hF) ? l : (l + 4'd1);
    endfunction

    state_t      state_q, state_d;
    logic        frame_q;
    logic [3:0]  btn_q;
    logic [3:0]  pend_q, pend_d;
    logic [9:0]  frog_x_q, frog_x_d;
    logic [9:0]  frog_y_q, frog_y_d;
    logic [9:0]  car_x_q, car_x_d;
    logic [3:0]  level_q, level_d;
    logic [15:0] hit_cnt_q, hit_cnt_d;

    logic        tick;
    logic [3:0]  btn_now;
    logic [3:0]  btn_rise;
    logic [3:0]  pend_all;
    logic [9:0]  mv_x, mv_y;
    logic [10:0] car_sum;
    logic [9:0]  car_adv;
    logic        collide;
    logic        hit_last;

    // Button bit order: [3]=Up, [2]=Down, [1]=Left, [0]=Right (also move priority).
    assign btn_now  = {i_Btn_Up, i_Btn_Down, i_Btn_Left, i_Btn_Right};
    assign btn_rise = btn_now & ~btn_q;
    // A press arriving on the tick cycle itself is honoured at that tick.
    assign pend_all = pend_q | btn_rise;
    assign tick     = i_Frame_Start & ~frame_q;
    assign hit_last = (hit_cnt_q <= 16'd1);

    // Edge-detector history; frame history resets high so a strobe already
    // high when reset is released does not count as a tick.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            frame_q <= 1'b1;
            btn_q   <= 4'b0000;
        end else begin
            frame_q <= i_Frame_Start;
            btn_q   <= btn_now;
        end
    end

    // Candidate frog move, car advance and collision test on updated positions.
    always_comb begin
        mv_x = frog_x_q;
        mv_y = frog_y_q;
        if (pend_all[3])      mv_y = step_dec(frog_y_q);
        else if (pend_all[2]) mv_y = step_inc(frog_y_q, Y_MAX);
        else if (pend_all[1]) mv_x = step_dec(frog_x_q);
        else if (pend_all[0]) mv_x = step_inc(frog_x_q, X_MAX);

        car_sum = {1'b0, car_x_q} + {1'b0, STEP10} + {7'b0, level_q};
        car_adv = (car_sum >= H_AREA) ? 10'(car_sum - H_AREA) : car_sum[9:0];

        collide = ({1'b0, mv_x} < ({1'b0, car_adv} + {1'b0, TILE10})) &&
                  ({1'b0, car_adv} < ({1'b0, mv_x} + {1'b0, TILE10})) &&
                  ({1'b0, mv_y} < ({1'b0, CAR_Y0} + {1'b0, TILE10})) &&
                  ({1'b0, CAR_Y0} < ({1'b0, mv_y} + {1'b0, TILE10}));
    end

    // FSM state register.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // FSM next-state logic; transitions happen only on a frame tick.
    always_comb begin
        state_d = state_q;
        if (tick) begin
            case (state_q)
                S_IDLE: if (|pend_all) state_d = S_PLAY;
                S_PLAY: begin
                    if (collide)            state_d = S_HIT;
                    else if (mv_y == 10'd0) state_d = S_WIN;
                end
                S_HIT:  if (hit_last) state_d = S_PLAY;
                S_WIN:  state_d = S_PLAY;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // FSM outputs.
    always_comb begin
        o_State     = state_q;
        o_Collision = (state_q == S_HIT);
    end

    // Game datapath next values: frog, car, level, freeze counter, move latches.
    always_comb begin
        frog_x_d  = frog_x_q;
        frog_y_d  = frog_y_q;
        car_x_d   = car_x_q;
        level_d   = level_q;
        hit_cnt_d = hit_cnt_q;
        pend_d    = tick ? 4'b0000 : pend_all;
        if (tick) begin
            case (state_q)
                S_IDLE: begin
                    // The car starts rolling on the very tick play begins;
                    // the starting press itself never moves the frog.
                    if (|pend_all) car_x_d = car_adv;
                end
                S_PLAY: begin
                    frog_x_d = mv_x;
                    frog_y_d = mv_y;
                    car_x_d  = car_adv;
                    if (collide)            hit_cnt_d = HIT_LEN;
                    else if (mv_y == 10'd0) level_d   = level_inc(level_q);
                end
                S_HIT: begin
                    if (hit_last) begin
                        frog_x_d  = FROG_X0;
                        frog_y_d  = FROG_Y0;
                        level_d   = 4'd0;
                        hit_cnt_d = 16'd0;
                    end else begin
                        hit_cnt_d = hit_cnt_q - 16'd1;
                    end
                end
                S_WIN: begin
                    frog_x_d = FROG_X0;
                    frog_y_d = FROG_Y0;
                end
                default: ;
            endcase
        end
    end

    // Game datapath registers.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            frog_x_q  <= FROG_X0;
            frog_y_q  <= FROG_Y0;
            car_x_q   <= 10'd0;
            level_q   <= 4'd0;
            hit_cnt_q <= 16'd0;
            pend_q    <= 4'b0000;
        end else begin
            frog_x_q  <= frog_x_d;
            frog_y_q  <= frog_y_d;
            car_x_q   <= car_x_d;
            level_q   <= level_d;
            hit_cnt_q <= hit_cnt_d;
            pend_q    <= pend_d;
        end
    end

    assign o_Frog_X = frog_x_q;
    assign o_Frog_Y = frog_y_q;
    assign o_Car_X  = car_x_q;
    assign o_Car_Y  = CAR_Y0;
    assign o_Level  = level_q;

endmodule

// File: tb/tb_frog_game_ctrl.sv
// Directed bench for frog_game_ctrl: scripted button/frame sequences with
// hand-computed positions, levels and states.
module tb_frog_game_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       fs = 1'b0;
    logic       b_up = 1'b0, b_dn = 1'b0, b_lf = 1'b0, b_rt = 1'b0;
    logic [9:0] frog_x, frog_y, car_x, car_y;
    logic       coll;
    logic [3:0] level;
    logic [1:0] state;

    int err_cnt = 0;
    int chk_cnt = 0;

    localparam logic [3:0] UP = 4'b1000, DN = 4'b0100, LF = 4'b0010;

    frog_game_ctrl dut (
        .i_Clk         (clk),
        .i_Rst_L       (rst_n),
        .i_Frame_Start (fs),
        .i_Btn_Up      (b_up),
        .i_Btn_Down    (b_dn),
        .i_Btn_Left    (b_lf),
        .i_Btn_Right   (b_rt),
        .o_Frog_X      (frog_x),
        .o_Frog_Y      (frog_y),
        .o_Car_X       (car_x),
        .o_Car_Y       (car_y),
        .o_Collision   (coll),
        .o_Level       (level),
        .o_State       (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int act, input int exp);
        chk_cnt++;
        if (act != exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Pulse the given buttons ({up,down,left,right}) high for two cycles.
    task automatic press(input logic [3:0] b);
        @(negedge clk);
        {b_up, b_dn, b_lf, b_rt} = b;
        repeat (2) @(negedge clk);
        {b_up, b_dn, b_lf, b_rt} = 4'b0000;
        @(negedge clk);
    endtask

    task automatic tick();
        @(negedge clk);
        fs = 1'b1;
        @(negedge clk);
        fs = 1'b0;
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic up_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            press(UP);
            tick();
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_state", state, 0);
        chk("rst_frog_x", frog_x, 304);
        chk("rst_frog_y", frog_y, 448);
        chk("rst_car_x", car_x, 0);
        chk("rst_car_y", car_y, 224);
        chk("rst_coll", coll, 0);
        chk("rst_level", level, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Idle frames with no buttons change nothing.
        ticks(3);
        chk("idle_state", state, 0);
        chk("idle_car_x", car_x, 0);
        chk("idle_frog_x", frog_x, 304);
        chk("idle_frog_y", frog_y, 448);

        // Start press enters PLAY without moving the frog; car begins rolling.
        press(UP);
        tick();
        chk("start_state", state, 1);
        chk("start_frog_y", frog_y, 448);
        press(UP);
        tick();
        chk("up1_frog_y", frog_y, 416);
        chk("up1_car_x", car_x, 4);

        // Car wrap-around at the right edge.
        ticks(317);
        chk("pre_wrap_car", car_x, 638);
        tick();
        chk("wrap_car", car_x, 0);

        // Up has priority over Left when both arrive before one tick.
        press(UP | LF);
        tick();
        chk("prio_frog_y", frog_y, 384);
        chk("prio_frog_x", frog_x, 304);
        chk("prio_car_x", car_x, 2);

        // Climb to the top row, then win.
        up_ticks(11);
        chk("top_frog_y", frog_y, 32);
        chk("top_car_x", car_x, 24);
        chk("top_state", state, 1);
        up_ticks(1);
        chk("win_state", state, 3);
        chk("win_level", level, 1);
        chk("win_frog_y", frog_y, 0);
        tick();
        chk("win_ret_state", state, 1);
        chk("win_ret_frog_x", frog_x, 304);
        chk("win_ret_frog_y", frog_y, 448);
        chk("win_ret_car", car_x, 26);
        tick();
        chk("lvl1_car_step", car_x, 29);

        // Park just below the lane, let the car approach, then step into it.
        up_ticks(6);
        chk("lane_wait_y", frog_y, 256);
        chk("lane_wait_car", car_x, 47);
        ticks(84);
        chk("lane_wait_state", state, 1);
        press(UP);
        @(negedge clk);
        fs = 1'b1;
        chk("pre_hit_coll", coll, 0);
        @(posedge clk);
        #1;
        chk("hit_coll", coll, 1);
        chk("hit_state", state, 2);
        chk("hit_car_x", car_x, 302);
        chk("hit_frog_y", frog_y, 224);
        chk("hit_level", level, 1);
        @(negedge clk);
        fs = 1'b0;
        @(negedge clk);
        ticks(59);
        chk("frz_state", state, 2);
        chk("frz_car_x", car_x, 302);
        chk("frz_frog_y", frog_y, 224);
        chk("frz_level", level, 1);
        tick();
        chk("hit_end_state", state, 1);
        chk("hit_end_coll", coll, 0);
        chk("hit_end_level", level, 0);
        chk("hit_end_frog_x", frog_x, 304);
        chk("hit_end_frog_y", frog_y, 448);
        chk("hit_end_car", car_x, 302);

        // Down saturates at the bottom row; level 0 again so step is 2.
        press(DN);
        tick();
        chk("down_sat_y", frog_y, 448);
        chk("down_sat_car", car_x, 304);

        // A strobe held for five cycles is a single tick.
        @(negedge clk);
        fs = 1'b1;
        repeat (5) @(negedge clk);
        fs = 1'b0;
        repeat (2) @(negedge clk);
        chk("long_strobe_car", car_x, 306);

        // Into HIT again, then asynchronous reset in the middle of the freeze.
        up_ticks(7);
        chk("hit2_state", state, 2);
        chk("hit2_car", car_x, 320);
        ticks(3);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_state", state, 0);
        chk("arst_coll", coll, 0);
        chk("arst_frog_x", frog_x, 304);
        chk("arst_frog_y", frog_y, 448);
        chk("arst_car_x", car_x, 0);
        chk("arst_car_y", car_y, 224);
        chk("arst_level", level, 0);

        // Strobe already high at reset release is not a tick.
        fs = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        press(UP);
        repeat (2) @(negedge clk);
        chk("rel_hi_state", state, 0);
        fs = 1'b0;
        repeat (2) @(negedge clk);
        chk("rel_fall_state", state, 0);
        tick();
        chk("rel_tick_state", state, 1);
        chk("rel_tick_frog_y", frog_y, 448);
        chk("rel_tick_car", car_x, 2);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
